alu_mul_ctrl: RTL and testbench

- Iterative shift-add multiplier sequencer that borrows the shared ALU in add mode, one partial product per cycle.
- Produces the low WIDTH bits of an unsigned product plus an exact overflow flag.
- Sits beside the ALU; the datapath ALU-operand mux selects this block's operands while alu_req_o is high.

---
 rtl/alu_mul_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_mul_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_ctrl.sv
// Shift-add multiplier sequencer that borrows the shared ALU in add mode, one partial product
// per cycle. Optional early termination is enabled by defining MUL_EARLY_TERM_EN.
module alu_mul_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             ready_o,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             alu_req_o,
    output logic [WIDTH-1:0] alu_src_a_o,
    output logic [WIDTH-1:0] alu_src_b_o,
    output logic [2:0]       alu_control_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_carry_i
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [2:0]      AluAdd  = 3'b000;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              lost_q, lost_d;
    logic              ovf_q, ovf_d;
    logic              last_iter;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        lost_d    = lost_q;
        ovf_d     = ovf_q;
        last_iter = (cnt_q == LastCnt);
`ifdef MUL_EARLY_TERM_EN
        last_iter = last_iter || ((mplier_q >> 1) == '0);
`else
`endif

        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    acc_d    = '0;
                    mcand_d  = op_a_i;
                    mplier_d = op_b_i;
                    cnt_d    = '0;
                    lost_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (mplier_q[0]) begin
                    acc_d = alu_result_i;
                    // A set bit already shifted out of mcand means this term alone exceeds WIDTH.
                    ovf_d = ovf_q | alu_carry_i | lost_q;
                end
                lost_d   = lost_q | mcand_q[WIDTH-1];
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (result_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready_o        = (state_q == StIdle);
    assign alu_req_o      = (state_q == StRun);
    assign alu_src_a_o    = alu_req_o ? acc_q : '0;
    assign alu_src_b_o    = alu_req_o ? mcand_q : '0;
    assign alu_control_o  = AluAdd;
    assign result_valid_o = (state_q == StDone);
    assign result_o       = result_valid_o ? acc_q : '0;
    assign overflow_o     = result_valid_o ? ovf_q : 1'b0;

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Directed self-checking bench for alu_mul_ctrl; models the shared ALU as a plain adder.
module tb_alu_mul_ctrl;

    localparam int unsigned W = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [W-1:0]  op_a_i = '0;
    logic [W-1:0]  op_b_i = '0;
    logic          ready_o;
    logic          flush_i = 1'b0;
    logic [W-1:0]  result_o;
    logic          overflow_o;
    logic          result_valid_o;
    logic          result_ready_i = 1'b0;
    logic          alu_req_o;
    logic [W-1:0]  alu_src_a_o;
    logic [W-1:0]  alu_src_b_o;
    logic [2:0]    alu_control_o;
    logic [W-1:0]  alu_result_i;
    logic          alu_carry_i;
    logic [W:0]    alu_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    assign alu_sum      = {1'b0, alu_src_a_o} + {1'b0, alu_src_b_o};
    assign alu_result_i = alu_sum[W-1:0];
    assign alu_carry_i  = alu_sum[W];

    alu_mul_ctrl #(.WIDTH(W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .op_a_i        (op_a_i),
        .op_b_i        (op_b_i),
        .ready_o       (ready_o),
        .flush_i       (flush_i),
        .result_o      (result_o),
        .overflow_o    (overflow_o),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .alu_req_o     (alu_req_o),
        .alu_src_a_o   (alu_src_a_o),
        .alu_src_b_o   (alu_src_b_o),
        .alu_control_o (alu_control_o),
        .alu_result_i  (alu_result_i),
        .alu_carry_i   (alu_carry_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected RUN cycle count for a given multiplier.
    function automatic int exp_run(input logic [W-1:0] b);
        int n;
        n = W;
`ifdef MUL_EARLY_TERM_EN
        n = 1;
        while (n < W && (b >> n) != '0) n++;
`else
`endif
        return n;
    endfunction

    task automatic reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_valid"}, 64'(result_valid_o), 64'd0);
        check({tag, "_result"}, 64'(result_o), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
        check({tag, "_req"}, 64'(alu_req_o), 64'd0);
        check({tag, "_srca"}, 64'(alu_src_a_o), 64'd0);
        check({tag, "_srcb"}, 64'(alu_src_b_o), 64'd0);
        check({tag, "_ctrl"}, 64'(alu_control_o), 64'd0);
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        op_a_i  = a;
        op_b_i  = b;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic handshake();
        result_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        result_ready_i = 1'b0;
    endtask

    task automatic mul_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_res, input logic exp_ovf);
        int lat;
        int reqs;
        accept(a, b);
        lat  = 0;
        reqs = 0;
        while (!result_valid_o && lat < 200) begin
            if (alu_req_o) reqs++;
            @(posedge clk_i);
            #1;
            lat++;
        end
        check({tag, "_valid"}, 64'(result_valid_o), 64'd1);
        check({tag, "_result"}, 64'(result_o), 64'(exp_res));
        check({tag, "_ovf"}, 64'(overflow_o), 64'(exp_ovf));
        check({tag, "_latency"}, 64'(lat), 64'(exp_run(b)));
        check({tag, "_reqs"}, 64'(reqs), 64'(exp_run(b)));
        handshake();
        check({tag, "_ready_after"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        int seen_valid;

        #2;
        reset_outputs("por");
        #10;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        mul_check("m7x6", 32'd7, 32'd6, 32'd42, 1'b0);
        mul_check("m64k", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        mul_check("msb2", 32'h8000_0000, 32'd2, 32'h0, 1'b1);
        mul_check("maxsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b1);
        mul_check("maxx1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        mul_check("x0", 32'h1234_5678, 32'd0, 32'h0, 1'b0);
        mul_check("fit", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);

        // Result held while the consumer stalls; start in DONE is ignored.
        accept(32'd3, 32'd4);
        for (int i = 0; i < 40 && !result_valid_o; i++) begin
            @(posedge clk_i);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            op_a_i  = 32'd9;
            op_b_i  = 32'd9;
            start_i = (i == 2);
            @(posedge clk_i);
            #1;
            check("hold_result", 64'(result_o), 64'd12);
            check("hold_ovf", 64'(overflow_o), 64'd0);
            check("hold_ready", 64'(ready_o), 64'd0);
        end
        start_i = 1'b0;
        handshake();
        check("hold_ready_after", 64'(ready_o), 64'd1);
        check("hold_valid_after", 64'(result_valid_o), 64'd0);

        // Flush during iteration 10.
        accept(32'h1234, 32'h5678);
        repeat (10) begin
            @(posedge clk_i);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_ready", 64'(ready_o), 64'd1);
        check("flush_req", 64'(alu_req_o), 64'd0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid_o) seen_valid++;
            @(posedge clk_i);
            #1;
        end
        check("flush_no_valid", 64'(seen_valid), 64'd0);
        mul_check("post_flush", 32'd3, 32'd5, 32'd15, 1'b0);

        // Flush together with start in IDLE blocks the request.
        flush_i = 1'b1;
        accept(32'd2, 32'd2);
        flush_i = 1'b0;
        check("flush_start_ready", 64'(ready_o), 64'd1);
        check("flush_start_req", 64'(alu_req_o), 64'd0);

        // Asynchronous reset mid-RUN at cnt=20.
        accept(32'hFFFF, 32'hFFFF_FFFF);
        repeat (20) begin
            @(posedge clk_i);
            #1;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        reset_outputs("arst");
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        reset_outputs("arst_rel");
        mul_check("post_rst", 32'd2, 32'd3, 32'd6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
